// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer
//  Description : Sequencer for a single-multiplier FIR datapath. On each
//                sample_tick the new sample is written into a circular
//                history buffer. TAPS coefficient/sample pairs are then
//                walked through one MAC, and the sum is presented with a
//                one-cycle out_valid pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          system clock, all logic on the rising edge
//    rst          synchronous active-high reset
//    sample_tick  one-cycle strobe: sample_in holds a new sample
//    sample_in    signed input sample
//    coef_addr    coefficient ROM address (tap index k)
//    coef_rd      coefficient ROM read enable, high only while running
//    coef_data    signed ROM data, valid one cycle after coef_rd/coef_addr
//    filter_out   signed filter result, held until the next result
//    out_valid    one-cycle pulse when filter_out updates
//    busy         high whenever a computation is in progress
//    overrun      sticky flag: a tick arrived while busy (cleared by rst)
// ============================================================================
module fir_mac_sequencer #(
    parameter int TAPS   = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_tick,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic        [ADDR_W-1:0] coef_addr,
    output logic                     coef_rd,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [ACC_W-1:0]  filter_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int                PROD_W   = DATA_W + COEF_W;
    localparam logic [ADDR_W-1:0] c_last_k = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] c_one    = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_q,      state_d;
    logic        [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic        [ADDR_W-1:0]   k_q,          k_d;
    logic signed [ACC_W-1:0]    acc_q,        acc_d;
    logic signed [DATA_W-1:0]   samp_q,       samp_d;
    logic signed [DATA_W-1:0]   hist_q [TAPS];
    logic signed [DATA_W-1:0]   hist_d [TAPS];
    logic signed [ACC_W-1:0]    filter_out_q, filter_out_d;
    logic                       out_valid_q,  out_valid_d;
    logic                       overrun_q,    overrun_d;

    logic        [ADDR_W-1:0]   w_hist_idx;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_mac_sum;

    // Tap k pairs coefficient k with the sample k positions older than the
    // newest one; the pointer arithmetic wraps naturally because TAPS is a
    // power of two.
    assign w_hist_idx = wr_ptr_q - k_q;

    // The sample register and the ROM output both refer to the pair issued in
    // the previous cycle, so they are multiplied together here. Size casts
    // keep the operands signed, giving a sign-extended full-width product.
    assign w_prod     = PROD_W'(samp_q) * PROD_W'(coef_data);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_mac_sum  = acc_q + w_prod_ext;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        k_d          = k_q;
        acc_d        = acc_q;
        samp_d       = samp_q;
        hist_d       = hist_q;
        filter_out_d = filter_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;

        // A tick that arrives in any busy state is dropped and flagged.
        if (sample_tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    hist_d[wr_ptr_q] = sample_in;
                    acc_d            = '0;
                    k_d              = '0;
                    state_d          = ST_RUN;
                end
            end

            ST_RUN: begin
                samp_d = hist_q[w_hist_idx];
                // The first RUN cycle has no pair in flight yet.
                if (k_q != '0) begin
                    acc_d = w_mac_sum;
                end
                k_d = k_q + c_one;
                if (k_q == c_last_k) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Fold in the last pair directly into the output register.
                filter_out_d = w_mac_sum;
                out_valid_d  = 1'b1;
                wr_ptr_d     = wr_ptr_q + c_one;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            samp_q       <= '0;
            filter_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            samp_q       <= samp_d;
            filter_out_q <= filter_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            hist_q       <= hist_d;
        end
    end

    assign coef_addr  = k_q;
    assign coef_rd    = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign filter_out = filter_out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_sequencer
//  Description : Self-checking bench for fir_mac_sequencer. Two instances run
//                in lock-step from the same stimulus: the default 20-bit
//                accumulator and an 18-bit one that exercises wrap-around.
//                Expected results come from a direct convolution model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int TAPS   = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 20;
    localparam int ACC_N  = 18;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     sample_tick;
    logic signed [DATA_W-1:0] sample_in;

    logic        [ADDR_W-1:0] coef_addr,   coef_addr_n;
    logic                     coef_rd,     coef_rd_n;
    logic signed [COEF_W-1:0] coef_data,   coef_data_n;
    logic signed [ACC_W-1:0]  filter_out;
    logic signed [ACC_N-1:0]  filter_out_n;
    logic                     out_valid,   out_valid_n;
    logic                     busy,        busy_n;
    logic                     overrun,     overrun_n;

    logic signed [COEF_W-1:0] rom [TAPS];

    int errors = 0;
    int checks = 0;

    longint xh [TAPS];
    logic   ovr_m;

    always #5 clk = ~clk;

    fir_mac_sequencer #(
        .TAPS(TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .sample_in(sample_in),
        .coef_addr(coef_addr), .coef_rd(coef_rd), .coef_data(coef_data),
        .filter_out(filter_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    fir_mac_sequencer #(
        .TAPS(TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_N)
    ) dut_n (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .sample_in(sample_in),
        .coef_addr(coef_addr_n), .coef_rd(coef_rd_n), .coef_data(coef_data_n),
        .filter_out(filter_out_n), .out_valid(out_valid_n), .busy(busy_n), .overrun(overrun_n)
    );

    // Synchronous coefficient ROMs, one per instance.
    always @(posedge clk) begin
        if (coef_rd)   coef_data   <= rom[coef_addr];
        if (coef_rd_n) coef_data_n <= rom[coef_addr_n];
    end

    // ---------------- reference model: direct convolution ----------------
    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) xh[i] = 0;
    endfunction

    function automatic void model_push(input longint s);
        for (int i = TAPS - 1; i > 0; i--) xh[i] = xh[i-1];
        xh[0] = s;
    endfunction

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(rom[k]) * xh[k];
        return s;
    endfunction

    // Two's-complement wrap of v to a w-bit signed value.
    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = v & ((64'sd1 <<< w) - 64'sd1);
        if (m[w-1]) m = m - (64'sd1 <<< w);
        return m;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold rst for n edges with sample_tick toggling; the last edge carries a
    // tick, which must be lost.
    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            sample_tick = i[0];
            sample_in   = DATA_W'($urandom);
            @(posedge clk); #1;
        end
        rst         = 1'b0;
        sample_tick = 1'b0;
        model_clear();
        ovr_m = 1'b0;
    endtask

    // Issue one tick and wait for its result. With ovr_at > 0 a second tick
    // lands ovr_at edges after the first one. Returns one time unit after the
    // edge that raises out_valid, so back-to-back calls give TAPS+2 spacing.
    task automatic send(input logic signed [DATA_W-1:0] s, input int ovr_at);
        longint y;
        int     lat;
        sample_in   = s;
        sample_tick = 1'b1;
        model_push(longint'(s));
        y = model_y();
        @(posedge clk); #1;
        sample_tick = 1'b0;
        sample_in   = DATA_W'($urandom);
        check("busy_after_tick", busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (ovr_at > 0 && lat == ovr_at - 1) sample_tick = 1'b1;
            @(posedge clk); #1;
            lat++;
            sample_tick = 1'b0;
            if (ovr_at > 0 && lat == ovr_at) ovr_m = 1'b1;
        end
        check("latency", lat, 9);
        check("filter_out", filter_out, wrap(y, ACC_W));
        check("filter_out_narrow", filter_out_n, wrap(y, ACC_N));
        check("out_valid_narrow", out_valid_n, 1);
        check("overrun", overrun, ovr_m);
    endtask

    // Quiet cycles: no pulses, not busy, result held.
    task automatic idle(input int n, input string tag);
        int v = 0;
        int b = 0;
        int ch = 0;
        logic signed [ACC_W-1:0] f0;
        f0 = filter_out;
        repeat (n) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || out_valid_n !== 1'b0) v++;
            if (busy !== 1'b0) b++;
            if (filter_out !== f0) ch++;
        end
        check({tag, "_valid_pulses"}, v, 0);
        check({tag, "_busy_cycles"}, b, 0);
        check({tag, "_result_changes"}, ch, 0);
    endtask

    // Unit impulse against ROM 1..8: results 1..8, then 0.
    task automatic impulse(input string tag);
        for (int k = 0; k < TAPS; k++) rom[k] = COEF_W'(k + 1);
        for (int i = 0; i <= TAPS; i++) begin
            send((i == 0) ? DATA_W'(1) : DATA_W'(0), 0);
            check({tag, "_const"}, filter_out, (i < TAPS) ? i + 1 : 0);
            if (i == 0) begin
                @(posedge clk); #1;
                check({tag, "_pulse_width"}, out_valid, 0);
                idle(39, tag);
            end else begin
                idle(40, tag);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        sample_tick = 1'b0;
        sample_in   = '0;
        for (int k = 0; k < TAPS; k++) rom[k] = '0;
        model_clear();
        ovr_m = 1'b0;
        @(posedge clk); #1;

        // Reset with toggling ticks.
        do_reset(2);
        check("rst_filter_out", filter_out, 0);
        check("rst_filter_out_narrow", filter_out_n, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_coef_rd", coef_rd, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_overrun", overrun, 0);
        idle(12, "post_reset");

        // Impulse response.
        impulse("impulse");

        // Extremes: 16384*n; the 18-bit instance wraps on the eighth result.
        do_reset(2);
        for (int k = 0; k < TAPS; k++) rom[k] = -8'sd128;
        for (int i = 0; i < TAPS; i++) send(-8'sd128, 0);
        check("extreme_last_wide", filter_out, 131072);
        check("extreme_last_narrow", filter_out_n, -131072);

        // Overrun: second tick three edges after the first is dropped.
        for (int k = 0; k < TAPS; k++) rom[k] = COEF_W'(k + 1);
        idle(5, "pre_overrun");
        check("overrun_clear_before", overrun, 0);
        send(DATA_W'($urandom), 3);
        idle(20, "overrun_gap");
        check("overrun_sticky", overrun, 1);
        check("overrun_sticky_narrow", overrun_n, 1);
        send(DATA_W'($urandom), 0);
        idle(5, "overrun_after");

        // Reset in the middle of RUN.
        sample_in   = 8'sd5;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("midrun_k", coef_addr, 4);
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        ovr_m = 1'b0;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_coef_rd", coef_rd, 0);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_overrun", overrun, 0);
        check("midrun_rst_filter_out", filter_out, 0);
        idle(15, "after_midrun_rst");
        impulse("impulse_again");

        // Random samples and ROM at the minimum tick spacing.
        for (int k = 0; k < TAPS; k++) rom[k] = COEF_W'($urandom);
        for (int i = 0; i < 40; i++) send(DATA_W'($urandom), 0);
        @(posedge clk); #1;
        check("random_overrun_final", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
